// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Issues one instruction-memory
//            request at a time, collects the returned word into a small
//            circular fetch queue, and presents the queue head to decode.
//            A taken branch/jump (redirect) flushes the queue, reloads the
//            PC and discards any response still owed by memory.
// Ports    : clk            - sole clock, rising edge
//            reset          - asynchronous, active-low reset
//            redirect_valid - redirect the fetch stream this cycle
//            redirect_pc    - redirect target
//            ireq_valid/ireq_ready/ireq_addr - memory request handshake
//            iresp_valid/iresp_data          - memory response
//            out_valid/out_ready             - queue head handshake to decode
//            out_instr/out_pc/out_pc_plus_4  - queue head contents
//            out_excp       - head is a misaligned-fetch marker
// Config   : FETCH_ALIGN_CHECK_EN - when defined, a misaligned PC produces a
//            single excp marker entry instead of a memory request; when
//            undefined, redirect targets are forced word-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  input  logic        ireq_ready,
  output logic [31:0] ireq_addr,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic        out_excp
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;

  logic [31:0] fq_instr_q [FQ_DEPTH];
  logic [31:0] fq_pc_q    [FQ_DEPTH];

  logic        space_avail;
  logic        req_fire;
  logic        push;
  logic        pop;
  logic [31:0] push_instr;
  logic [31:0] push_pc;
  logic [31:0] redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic [FQ_DEPTH-1:0] fq_excp_q;
  logic                excp_sent_q, excp_sent_d;
  logic                misaligned;
  logic                align_push;
`endif

  assign space_avail = (count_q < DEPTH_C);
  assign req_fire    = ireq_valid & ireq_ready;
  assign pop         = out_valid & out_ready & ~redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign misaligned   = (state_q == ST_REQ) && (pc_q[1:0] != 2'b00);
  // The marker is written once per misaligned PC; the PC then parks until
  // the next redirect supplies a new stream.
  assign align_push   = misaligned & space_avail & ~excp_sent_q & ~redirect_valid;
  assign push         = ((state_q == ST_WAIT) & iresp_valid & ~redirect_valid) | align_push;
  assign push_instr   = align_push ? 32'h0 : iresp_data;
  assign push_pc      = align_push ? pc_q  : req_pc_q;
`else
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign push         = (state_q == ST_WAIT) & iresp_valid & ~redirect_valid;
  assign push_instr   = iresp_data;
  assign push_pc      = req_pc_q;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      excp_sent_q <= 1'b0;
    end else begin
      excp_sent_q <= excp_sent_d;
    end
  end

  always_comb begin
    excp_sent_d = excp_sent_q;
    if (redirect_valid) begin
      excp_sent_d = 1'b0;
    end else if (align_push) begin
      excp_sent_d = 1'b1;
    end
  end
`endif

  // Queue storage carries no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_instr_q[tail_q] <= push_instr;
      fq_pc_q[tail_q]    <= push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
      fq_excp_q[tail_q]  <= align_push;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d   = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d   = push ? tail_q + PTR_W'(1) : tail_q;

    case (state_q)
      ST_REQ: begin
        if (req_fire) begin
          state_d  = ST_WAIT;
          pc_d     = pc_q + 32'd4;
          req_pc_d = pc_q;
        end
      end
      ST_WAIT, ST_DROP: begin
        if (iresp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_tgt;
      count_d = '0;
      head_d  = tail_q;
      tail_d  = tail_q;
      // A response arriving with the redirect settles the debt; otherwise an
      // outstanding request must be drained before a new one may go out.
      if (iresp_valid) begin
        state_d = ST_REQ;
      end else if ((state_q == ST_WAIT) || (state_q == ST_DROP)) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    ireq_addr  = pc_q;
    // reset gates the request so nothing is offered while in reset, yet the
    // first request appears in the very first cycle after release.
    ireq_valid = reset && (state_q == ST_REQ) && !redirect_valid && space_avail;
`ifdef FETCH_ALIGN_CHECK_EN
    ireq_valid = ireq_valid && !misaligned;
`endif
    out_valid  = (count_q != '0);
    out_instr  = out_valid ? fq_instr_q[head_q] : 32'h0;
    out_pc     = out_valid ? fq_pc_q[head_q]    : 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
    out_excp   = out_valid & fq_excp_q[head_q];
`else
    out_excp   = 1'b0;
`endif
    out_pc_plus_4 = out_pc + 32'd4;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit. A small memory
//            responder answers each accepted request with addr ^ 32'hFFFFFFFF,
//            normally in the following cycle; resp_hold delays the answer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ireq_valid;
  logic        ireq_ready;
  logic [31:0] ireq_addr;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic        out_excp;

  int checks = 0;
  int errors = 0;

  logic        mem_pend;
  logic [31:0] mem_addr;
  logic        resp_hold;

  always #5 clk = ~clk;

  fetch_unit #(.FQ_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_ready    (ireq_ready),
    .ireq_addr     (ireq_addr),
    .iresp_valid   (iresp_valid),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_excp      (out_excp)
  );

  // Single-outstanding memory model.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_pend <= 1'b0;
      mem_addr <= 32'h0;
    end else if (ireq_valid && ireq_ready) begin
      mem_pend <= 1'b1;
      mem_addr <= ireq_addr;
    end else if (iresp_valid) begin
      mem_pend <= 1'b0;
    end
  end

  assign iresp_valid = mem_pend & ~resp_hold;
  assign iresp_data  = mem_addr ^ 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    ireq_ready     = 1'b0;
    out_ready      = 1'b0;
    resp_hold      = 1'b0;

    // ---------------- reset state ----------------
    cyc(); cyc();
    chk("rst_out_valid",  {31'b0, out_valid},  32'h0);
    chk("rst_ireq_valid", {31'b0, ireq_valid}, 32'h0);
    chk("rst_out_excp",   {31'b0, out_excp},   32'h0);
    chk("rst_out_instr",  out_instr,           32'h0);
    chk("rst_out_pc",     out_pc,              32'h0);
    chk("rst_ireq_addr",  ireq_addr,           32'h0);

    // ---------------- streaming fetch ----------------
    reset      = 1'b1;
    ireq_ready = 1'b1;
    out_ready  = 1'b1;
    #1;
    chk("first_ireq_valid", {31'b0, ireq_valid}, 32'h1);
    chk("first_ireq_addr",  ireq_addr,           32'h0);
    cyc();  // C1: waiting on response
    chk("c1_ireq_valid", {31'b0, ireq_valid}, 32'h0);
    chk("c1_out_valid",  {31'b0, out_valid},  32'h0);
    cyc();  // C2: first instruction visible
    chk("s0_out_valid", {31'b0, out_valid}, 32'h1);
    chk("s0_out_pc",    out_pc,             32'h0);
    chk("s0_out_instr", out_instr,          32'hFFFF_FFFF);
    chk("s0_pc_plus_4", out_pc_plus_4,      32'h4);
    chk("s0_ireq_addr", ireq_addr,          32'h4);
    cyc();
    chk("s1_gap_valid", {31'b0, out_valid}, 32'h0);
    cyc();
    chk("s1_out_pc",    out_pc,        32'h4);
    chk("s1_out_instr", out_instr,     32'hFFFF_FFFB);
    chk("s1_pc_plus_4", out_pc_plus_4, 32'h8);
    cyc(); cyc();
    chk("s2_out_pc",    out_pc,    32'h8);
    chk("s2_out_instr", out_instr, 32'hFFFF_FFF7);

    // ---------------- backpressure fills queue ----------------
    out_ready = 1'b0;
    reset_pulse();
    repeat (20) cyc();
    chk("full_ireq_valid", {31'b0, ireq_valid}, 32'h0);
    chk("full_ireq_addr",  ireq_addr,           32'h10);
    chk("full_out_valid",  {31'b0, out_valid},  32'h1);
    chk("full_head_pc",    out_pc,              32'h0);
    out_ready = 1'b1;
    cyc();
    chk("drain0_out_pc",     out_pc,              32'h4);
    chk("drain0_ireq_valid", {31'b0, ireq_valid}, 32'h1);
    chk("drain0_ireq_addr",  ireq_addr,           32'h10);
    cyc();
    chk("drain1_out_pc", out_pc, 32'h8);
    cyc();
    chk("drain2_out_pc", out_pc, 32'hC);
    cyc();
    chk("resume_out_pc",    out_pc,    32'h10);
    chk("resume_out_instr", out_instr, 32'hFFFF_FFEF);

    // ---------------- redirect while waiting ----------------
    out_ready = 1'b0;
    reset_pulse();
    cyc(); cyc(); cyc(); cyc();  // C4: two entries queued, request for 0x8 next
    resp_hold = 1'b1;
    cyc();  // C5: waiting on 0x8
    chk("rw_pre_out_valid", {31'b0, out_valid}, 32'h1);
    chk("rw_pre_out_pc",    out_pc,             32'h0);
    chk("rw_pre_ireq",      {31'b0, ireq_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    resp_hold      = 1'b0;
    #1;
    chk("rw_flush_valid", {31'b0, out_valid},  32'h0);
    chk("rw_drop_ireq",   {31'b0, ireq_valid}, 32'h0);
    chk("rw_drop_addr",   ireq_addr,           32'h100);
    cyc();
    chk("rw_dropped_valid", {31'b0, out_valid},  32'h0);
    chk("rw_req_valid",     {31'b0, ireq_valid}, 32'h1);
    chk("rw_req_addr",      ireq_addr,           32'h100);
    out_ready = 1'b1;
    cyc(); cyc();
    chk("rw_new_valid", {31'b0, out_valid}, 32'h1);
    chk("rw_new_pc",    out_pc,             32'h100);
    chk("rw_new_instr", out_instr,          32'hFFFF_FEFF);
    out_ready = 1'b0;

    // ---------------- redirect with response and pop ----------------
    cyc();  // response for 0x104 present, head 0x100 held
    chk("rr_pre_valid", {31'b0, out_valid},   32'h1);
    chk("rr_pre_resp",  {31'b0, iresp_valid}, 32'h1);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    chk("rr_redirect_blocks_req", {31'b0, ireq_valid}, 32'h0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("rr_out_valid",  {31'b0, out_valid},  32'h0);
    chk("rr_ireq_valid", {31'b0, ireq_valid}, 32'h1);
    chk("rr_ireq_addr",  ireq_addr,           32'h200);
    cyc(); cyc();
    chk("rr_new_pc", out_pc, 32'h200);

    // ---------------- misaligned redirect target ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("ma_no_req",  {31'b0, ireq_valid}, 32'h0);
    chk("ma_pc_held", ireq_addr,           32'h102);
    cyc();
    chk("ma_valid", {31'b0, out_valid}, 32'h1);
    chk("ma_excp",  {31'b0, out_excp},  32'h1);
    chk("ma_pc",    out_pc,             32'h102);
    chk("ma_instr", out_instr,          32'h0);
    cyc();
    chk("ma_single_entry", {31'b0, out_valid},  32'h0);
    chk("ma_still_no_req", {31'b0, ireq_valid}, 32'h0);
`else
    chk("ma_req_valid", {31'b0, ireq_valid}, 32'h1);
    chk("ma_aligned",   ireq_addr,           32'h100);
    chk("ma_excp_zero", {31'b0, out_excp},   32'h0);
`endif

    // ---------------- reset mid-WAIT ----------------
    out_ready = 1'b0;
    resp_hold = 1'b0;
    reset_pulse();
    cyc(); cyc(); cyc(); cyc(); cyc(); cyc();  // C6: three entries queued
    resp_hold = 1'b1;
    cyc();  // C7: waiting on 0xC
    chk("rm_pre_valid", {31'b0, out_valid},  32'h1);
    chk("rm_pre_ireq",  {31'b0, ireq_valid}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rm_out_valid",  {31'b0, out_valid},  32'h0);
    chk("rm_ireq_valid", {31'b0, ireq_valid}, 32'h0);
    chk("rm_out_excp",   {31'b0, out_excp},   32'h0);
    chk("rm_out_instr",  out_instr,           32'h0);
    chk("rm_out_pc",     out_pc,              32'h0);
    chk("rm_ireq_addr",  ireq_addr,           32'h0);
    resp_hold = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    chk("rm_rel_ireq_valid", {31'b0, ireq_valid}, 32'h1);
    chk("rm_rel_ireq_addr",  ireq_addr,           32'h0);
    cyc();
    chk("rm_rel_wait", {31'b0, ireq_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter FQ_DEPTH, default 4: fetch-queue entries; SHALL be a power of two, range 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Ports SHALL be exactly as follows:
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  asynchronous, active-low; 0 = in reset.
  - redirect_valid  in  1  branch/jump resolved taken; redirect this cycle.
  - redirect_pc  in  32  redirect target.
  - ireq_valid  out  1  instruction-memory request.
  - ireq_ready  in  1  memory accepts request.
  - ireq_addr  out  32  request address.
  - iresp_valid  in  1  response data valid, for the single outstanding request.
  - iresp_data  in  32  instruction word.
  - out_valid  out  1  queue head valid toward decode.
  - out_ready  in  1  decode accepts head; low = stallF.
  - out_instr  out  32  head instruction.
  - out_pc  out  32  head PC.
  - out_pc_plus_4  out  32  head PC + 4.
  - out_excp  out  1  head is a misaligned-fetch marker (REQ-020).

Function
REQ-004 Internal registers: pc (32), state {REQ, WAIT, DROP}, FQ_DEPTH-entry circular queue {instr, pc, excp}, count (log2(FQ_DEPTH)+1 bits).
REQ-005 ireq_addr SHALL equal pc.
REQ-006 ireq_valid SHALL be 1 iff state==REQ, redirect_valid==0, count<FQ_DEPTH.
REQ-007 Request handshake = ireq_valid & ireq_ready: pc <= pc+4 (mod 2^32), state <= WAIT, the issued address is latched as the request PC.
REQ-008 At most one request outstanding; no request is issued in WAIT or DROP.
REQ-009 In WAIT, iresp_valid: enqueue {iresp_data, request PC, 0} at tail; state <= REQ.
REQ-010 In DROP, iresp_valid: discard the data; state <= REQ; no enqueue.
REQ-011 iresp_valid in REQ SHALL be ignored.
REQ-012 Outputs out_* SHALL reflect the queue head combinationally from registers; out_valid = (count!=0); out_pc_plus_4 = out_pc+4.
REQ-013 Pop on out_valid & out_ready; same-cycle push and pop leave count unchanged; head/tail pointers wrap modulo FQ_DEPTH.
REQ-014 Head entry and out_* SHALL hold stable while out_valid & !out_ready.
REQ-015 redirect_valid (highest priority) at the clock edge:
  - queue flushed: count <= 0, head = tail;
  - pc <= redirect_pc;
  - state <= DROP if state was WAIT, or a response is otherwise still owed; else REQ;
  - any same-cycle iresp_valid is discarded and clears the owed response (state <= REQ);
  - any same-cycle pop is void.
REQ-016 First request after redirect SHALL be issued no earlier than the cycle after redirect_valid.
REQ-017 Latency: request accepted cycle N, iresp_valid cycle M>N, out_valid cycle M+1 (empty queue).
REQ-018 Queue overflow SHALL be impossible by construction (REQ-006); underflow pop SHALL have no effect.

Reset
REQ-019 While reset==0, asynchronously:
  - pc=RESET_PC, state=REQ, count=0, pointers=0;
  - out_valid=0, ireq_valid=0, out_excp=0, out_instr=0, out_pc=0.
  First request at RESET_PC SHALL be presentable the first cycle after reset release.

Configuration
REQ-020 Macro FETCH_ALIGN_CHECK_EN defined, in REQ with pc[1:0]!=0 and space available:
  - no memory request is issued;
  - enqueue {32'h0, pc, excp=1};
  - state stays REQ, pc holds until redirect.
REQ-021 Macro FETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 2'b00 when loaded; out_excp SHALL be constant 0.

Verification
REQ-022 Reset release, ireq_ready=1, memory returns iresp next cycle with data = address ^ 32'hFFFF_FFFF, out_ready=1 -> out_pc sequence 0x0,0x4,0x8; out_instr 0xFFFF_FFFF, 0xFFFF_FFFB, ...
REQ-023 out_ready=0 for 20 cycles, FQ_DEPTH=4 -> exactly 4 entries (pc 0x0..0xC), then ireq_valid=0; raise out_ready -> pops 0x0,0x4,0x8,0xC in order, fetching resumes at 0x10.
REQ-024 Redirect to 0x100 while WAIT for 0x8 -> the 0x8 response is dropped, queue emptied, next ireq_addr=0x100, next out_pc=0x100.
REQ-025 redirect_valid in the same cycle as iresp_valid and a pop -> nothing enqueued, count=0, ireq_addr=redirect_pc next cycle.
REQ-026 reset pulled low mid-WAIT with 3 entries queued -> outputs per REQ-019 immediately; after release, first ireq_addr=RESET_PC.
REQ-027 FETCH_ALIGN_CHECK_EN defined, redirect to 0x102 -> one entry out_excp=1, out_pc=0x102, no ireq_valid until next redirect; undefined -> ireq_addr=0x100.
